// File: rtl/bus_trace_capture_pkg.sv
// Shared types for the 6502 bus trace capture block.
// Trigger FSM encodings, trace entry layout and packing helper.
package bus_trace_capture_pkg;

    typedef enum logic [1:0] {
        TRACE_RUN   = 2'd0,
        TRACE_ARMED = 2'd1,
        TRACE_POST  = 2'd2,
        TRACE_DONE  = 2'd3
    } trace_state_t;

    localparam int TRACE_W = 26;

    typedef struct packed {
        logic        sync;
        logic        rw;
        logic [7:0]  d;
        logic [15:0] a;
    } trace_entry_t;

    function automatic trace_entry_t pack_entry(
        input logic        sync,
        input logic        rw,
        input logic [7:0]  d,
        input logic [15:0] a
    );
        trace_entry_t e;
        e.sync = sync;
        e.rw   = rw;
        e.d    = d;
        e.a    = a;
        return e;
    endfunction

endpackage

// File: rtl/bus_trace_capture_ram.sv
// Trace storage: DEPTH x TRACE_W register file, no reset on contents.
// Ports: clk, we/waddr/wdata (sync write), raddr/rdata (registered read).
module bus_trace_capture_ram
    import bus_trace_capture_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [TRACE_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [TRACE_W-1:0] rdata
);

    logic [TRACE_W-1:0] mem [DEPTH];

    // Read sees the pre-write contents when both hit one address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/bus_trace_capture.sv
// Circular trace of completed 6502 bus cycles with address trigger.
// Ports: bus inputs, clear/arm/trig_addr control, rd_* readback, status.
module bus_trace_capture
    import bus_trace_capture_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int POST  = 8
) (
    input  logic          clk,
    input  logic          rst_p,
    input  logic          phi2,
    input  logic          rw,
    input  logic          sync,
    input  logic [15:0]   a,
    input  logic [7:0]    d,
    input  logic          clear,
    input  logic          arm,
    input  logic [15:0]   trig_addr,
    input  logic [AW-1:0] rd_idx,
    output logic          rd_valid,
    output logic [15:0]   rd_a,
    output logic [7:0]    rd_d,
    output logic          rd_rw,
    output logic          rd_sync,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          cap_pulse,
    output logic [15:0]   last_pc,
    output logic [1:0]    state,
    output logic          triggered
);

    trace_state_t       st;
    logic               phi2_q;
    trace_entry_t       ent_q;
    logic [AW-1:0]      wptr;
    logic [7:0]         post_cnt;
    logic [AW-1:0]      raddr;
    logic [TRACE_W-1:0] ram_q;
    trace_entry_t       rd_ent;
    logic               cyc_end;
    logic               cap;
    logic               hit;
    logic               full;

    // Falling phi2 ends a cycle; the stored entry is the delayed copy.
    assign cyc_end = phi2_q & ~phi2;
    assign cap     = cyc_end & (st != TRACE_DONE) & ~clear;
    assign hit     = (ent_q.a == trig_addr);
    assign full    = (count == (AW+1)'(DEPTH));

    // Newest entry sits just behind the write pointer.
    assign raddr = wptr - AW'(1) - rd_idx;

    bus_trace_capture_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (cap),
        .waddr (wptr),
        .wdata (ent_q),
        .raddr (raddr),
        .rdata (ram_q)
    );

    assign rd_ent    = trace_entry_t'(ram_q);
    assign rd_a      = rd_valid ? rd_ent.a    : 16'h0;
    assign rd_d      = rd_valid ? rd_ent.d    : 8'h0;
    assign rd_rw     = rd_valid ? rd_ent.rw   : 1'b0;
    assign rd_sync   = rd_valid ? rd_ent.sync : 1'b0;
    assign state     = st;
    assign triggered = st[1];

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            phi2_q    <= 1'b0;
            ent_q     <= '0;
            wptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            cap_pulse <= 1'b0;
            last_pc   <= 16'h0;
            post_cnt  <= 8'h0;
            rd_valid  <= 1'b0;
            st        <= TRACE_RUN;
        end else begin
            phi2_q    <= phi2;
            ent_q     <= pack_entry(sync, rw, d, a);
            cap_pulse <= cap;
            rd_valid  <= ({1'b0, rd_idx} < count);
            if (clear) begin
                wptr     <= '0;
                count    <= '0;
                overflow <= 1'b0;
                last_pc  <= 16'h0;
                post_cnt <= 8'h0;
                st       <= TRACE_RUN;
            end else begin
                if (cap) begin
                    wptr <= wptr + AW'(1);
                    if (full) begin
                        overflow <= 1'b1;
                    end else begin
                        count <= count + (AW+1)'(1);
                    end
                    if (ent_q.sync) begin
                        last_pc <= ent_q.a;
                    end
                end
                unique case (st)
                    TRACE_RUN: begin
                        if (arm) begin
                            st <= TRACE_ARMED;
                        end
                    end
                    TRACE_ARMED: begin
                        if (cap && hit) begin
                            st       <= TRACE_POST;
                            post_cnt <= 8'(POST);
                        end
                    end
                    TRACE_POST: begin
                        if (cap) begin
                            post_cnt <= post_cnt - 8'd1;
                            if (post_cnt == 8'd1) begin
                                st <= TRACE_DONE;
                            end
                        end
                    end
                    TRACE_DONE: begin
                        st <= TRACE_DONE;
                    end
                endcase
            end
        end
    end

endmodule
